// File: rtl/move_scheduler.sv
// move_scheduler: merges player moves and gravity drops into a single
// valid/ack command stream for the grid controller, and owns pause state.
module move_scheduler #(
  parameter int GRAVITY_DIV = 25000000,
  parameter int LEVEL_STEP  = 1500000,
  parameter int MIN_PERIOD  = 2500000,
  parameter int CNT_W       = 25
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] button_code,
  input  logic       game_active,
  input  logic [3:0] level,
  output logic       cmd_valid,
  output logic [2:0] cmd,
  input  logic       cmd_ack,
  output logic       paused
);

  localparam int PW = CNT_W + 4;
  localparam logic [PW-1:0] GDIV  = PW'(GRAVITY_DIV);
  localparam logic [PW-1:0] LSTEP = PW'(LEVEL_STEP);
  localparam logic [PW-1:0] MINP  = PW'(MIN_PERIOD);

  localparam logic [2:0] CMD_NOP       = 3'd0;
  localparam logic [2:0] CMD_LEFT      = 3'd1;
  localparam logic [2:0] CMD_RIGHT     = 3'd2;
  localparam logic [2:0] CMD_ROT_CW    = 3'd3;
  localparam logic [2:0] CMD_ROT_CCW   = 3'd4;
  localparam logic [2:0] CMD_DROP      = 3'd5;
  localparam logic [2:0] CMD_HARD_DROP = 3'd6;

  typedef enum logic [1:0] {IDLE, ISSUE, GAP} state_t;

  state_t           state_q;
  logic             cmd_valid_q;
  logic [2:0]       cmd_q;
  logic             src_btn_q;
  logic             paused_q, paused_d;
  logic [3:0]       prev_code_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             grav_pending_q, grav_pending_d;
  logic             btn_pending_q, btn_pending_d;
  logic [2:0]       btn_cmd_q, btn_cmd_d;

  logic [PW-1:0] level_sub, period_raw, period;
  logic          press, running, tick, start_toggle, move_press;
  logic          load_grav, load_btn, btn_drop_ack;
  logic          map_ok;
  logic [2:0]    map_cmd;

  // Period shrinks with level but never underflows and never drops below the floor.
  always_comb begin
    level_sub  = PW'(level) * LSTEP;
    period_raw = (level_sub >= GDIV) ? '0 : GDIV - level_sub;
    period     = (period_raw < MINP) ? MINP : period_raw;
  end

  always_comb begin
    map_ok  = 1'b1;
    map_cmd = CMD_NOP;
    case (button_code)
      4'd1:    map_cmd = CMD_ROT_CW;
      4'd2:    map_cmd = CMD_ROT_CCW;
      4'd5:    map_cmd = CMD_HARD_DROP;
      4'd6:    map_cmd = CMD_DROP;
      4'd7:    map_cmd = CMD_LEFT;
      4'd8:    map_cmd = CMD_RIGHT;
      default: map_ok  = 1'b0;
    endcase
  end

  assign press        = (button_code != 4'd0) && (button_code != prev_code_q);
  assign running      = game_active && !paused_q;
  assign tick         = running && ({4'b0, cnt_q} >= (period - PW'(1)));
  assign start_toggle = press && (button_code == 4'd4) && game_active;
  assign move_press   = press && map_ok && running;
  assign load_grav    = (state_q == IDLE) && grav_pending_q;
  assign load_btn     = (state_q == IDLE) && !grav_pending_q && btn_pending_q;
  assign btn_drop_ack = (state_q == ISSUE) && cmd_ack && src_btn_q &&
                        ((cmd_q == CMD_DROP) || (cmd_q == CMD_HARD_DROP));

  // Later assignments take precedence: new events beat IDLE consumption,
  // entering pause beats a same-cycle tick, and an inactive game beats everything.
  always_comb begin
    cnt_d          = cnt_q;
    grav_pending_d = grav_pending_q;
    btn_pending_d  = btn_pending_q;
    btn_cmd_d      = btn_cmd_q;
    paused_d       = paused_q;

    if (!game_active || btn_drop_ack || tick) begin
      cnt_d = '0;
    end else if (running) begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    if (load_grav) grav_pending_d = 1'b0;
    if (tick)      grav_pending_d = 1'b1;

    if (load_btn) btn_pending_d = 1'b0;
    if (move_press) begin
      btn_pending_d = 1'b1;
      btn_cmd_d     = map_cmd;
    end

    if (start_toggle) begin
      paused_d = !paused_q;
      if (!paused_q) begin
        grav_pending_d = 1'b0;
        btn_pending_d  = 1'b0;
      end
    end

    if (!game_active) begin
      grav_pending_d = 1'b0;
      btn_pending_d  = 1'b0;
      paused_d       = 1'b0;
    end
  end

  // Handshake FSM: a presented command is held until acked, then a one-cycle gap.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      cmd_valid_q    <= 1'b0;
      cmd_q          <= CMD_NOP;
      src_btn_q      <= 1'b0;
      paused_q       <= 1'b0;
      prev_code_q    <= 4'd0;
      cnt_q          <= '0;
      grav_pending_q <= 1'b0;
      btn_pending_q  <= 1'b0;
      btn_cmd_q      <= CMD_NOP;
    end else begin
      prev_code_q    <= button_code;
      cnt_q          <= cnt_d;
      grav_pending_q <= grav_pending_d;
      btn_pending_q  <= btn_pending_d;
      btn_cmd_q      <= btn_cmd_d;
      paused_q       <= paused_d;

      case (state_q)
        IDLE: begin
          if (load_grav) begin
            cmd_q       <= CMD_DROP;
            cmd_valid_q <= 1'b1;
            src_btn_q   <= 1'b0;
            state_q     <= ISSUE;
          end else if (load_btn) begin
            cmd_q       <= btn_cmd_q;
            cmd_valid_q <= 1'b1;
            src_btn_q   <= 1'b1;
            state_q     <= ISSUE;
          end
        end
        ISSUE: begin
          if (cmd_ack) begin
            cmd_valid_q <= 1'b0;
            cmd_q       <= CMD_NOP;
            state_q     <= GAP;
          end
        end
        GAP: begin
          state_q <= IDLE;
        end
        default: begin
          state_q     <= IDLE;
          cmd_valid_q <= 1'b0;
          cmd_q       <= CMD_NOP;
        end
      endcase
    end
  end

  assign cmd_valid = cmd_valid_q;
  assign cmd       = cmd_q;
  assign paused    = paused_q;

endmodule

// File: tb/tb_move_scheduler.sv
// tb_move_scheduler: vector table, directed corner sequences and a randomized
// run against a countdown-based reference model of the scheduler.
module tb_move_scheduler;

  localparam int GD = 100;
  localparam int LS = 10;
  localparam int MP = 20;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] button_code = 4'd0;
  logic       game_active = 1'b0;
  logic [3:0] level = 4'd0;
  logic       cmd_ack = 1'b0;
  logic       cmd_valid;
  logic [2:0] cmd;
  logic       paused;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  move_scheduler #(
    .GRAVITY_DIV(GD),
    .LEVEL_STEP (LS),
    .MIN_PERIOD (MP),
    .CNT_W      (25)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .button_code(button_code),
    .game_active(game_active),
    .level      (level),
    .cmd_valid  (cmd_valid),
    .cmd        (cmd),
    .cmd_ack    (cmd_ack),
    .paused     (paused)
  );

  typedef struct {
    logic [3:0] code;
    logic       ack;
    logic       expValid;
    logic [2:0] expCmd;
    logic       expPaused;
  } vec_t;

  vec_t vq[$];

  // Reference model state: commands as ints (-1 = none), gravity as a countdown.
  int mPrev, mPer, mLeft, mOut, mBtn;
  bit mGap, mGrav, mPaused, mFromBtn;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] code, input logic act, input logic ack);
    button_code = code;
    game_active = act;
    cmd_ack     = ack;
  endtask

  task automatic tick1();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    reset = 1'b1;
    applyStimulus(4'd0, 1'b0, 1'b1);
    tick1();
    tick1();
    reset = 1'b0;
  endtask

  task automatic addVec(input int code, input bit ack, input bit v, input int c, input bit p);
    vec_t e;
    e.code = 4'(code); e.ack = ack; e.expValid = v; e.expCmd = 3'(c); e.expPaused = p;
    vq.push_back(e);
  endtask

  function automatic int expPeriod(input int lvl);
    int p;
    p = GD - lvl * LS;
    if (p < MP) p = MP;
    return p;
  endfunction

  function automatic int mapCode(input int code);
    case (code)
      1: return 3;
      2: return 4;
      5: return 6;
      6: return 5;
      7: return 1;
      8: return 2;
      default: return -1;
    endcase
  endfunction

  task automatic modelInit(input int per);
    mPrev = 0; mPer = per; mLeft = per; mOut = -1; mBtn = -1;
    mGap = 0; mGrav = 0; mPaused = 0; mFromBtn = 0;
  endtask

  task automatic modelStep(input int code, input bit act, input bit ack);
    bit press, counting, tickNow, dropAck, toggle;
    int mv;
    press    = (code != 0) && (code != mPrev);
    counting = act && !mPaused;
    dropAck  = 0;
    if (mOut >= 0) begin
      if (ack) begin
        dropAck = mFromBtn && (mOut == 5 || mOut == 6);
        mOut = -1;
        mGap = 1;
      end
    end else if (mGap) begin
      mGap = 0;
    end else if (mGrav) begin
      mOut = 5; mFromBtn = 0; mGrav = 0;
    end else if (mBtn >= 0) begin
      mOut = mBtn; mFromBtn = 1; mBtn = -1;
    end
    tickNow = counting && (mLeft <= 1);
    if (!act || dropAck || tickNow) mLeft = mPer;
    else if (counting) mLeft--;
    if (tickNow) mGrav = 1;
    mv = mapCode(code);
    if (press && counting && mv >= 0) mBtn = mv;
    toggle = press && (code == 4) && act;
    if (toggle) begin
      if (!mPaused) begin
        mGrav = 0;
        mBtn = -1;
      end
      mPaused = !mPaused;
    end
    if (!act) begin
      mGrav = 0; mBtn = -1; mPaused = 0;
    end
    mPrev = code;
  endtask

  task automatic measureGravity(input int lvl);
    int n, p;
    p = expPeriod(lvl);
    level = 4'(lvl);
    doReset();
    applyStimulus(4'd0, 1'b1, 1'b1);
    n = 0;
    do begin tick1(); n++; end while (!cmd_valid && n < 400);
    checkOutput($sformatf("grav L%0d first latency", lvl), n, p + 1);
    checkOutput($sformatf("grav L%0d first cmd", lvl), cmd, 5);
    n = 0;
    do begin tick1(); n++; end while (!cmd_valid && n < 400);
    checkOutput($sformatf("grav L%0d interval", lvl), n, p);
    checkOutput($sformatf("grav L%0d second cmd", lvl), cmd, 5);
  endtask

  initial begin
    int n, seen, frozen;
    int expV[7];
    int expC[7];

    doReset();
    checkOutput("reset valid", cmd_valid, 0);
    checkOutput("reset cmd", cmd, 0);
    checkOutput("reset paused", paused, 0);

    // code, ack, expected valid, cmd, paused after the edge
    addVec(0,1,0,0,0); addVec(7,1,0,0,0); addVec(7,1,1,1,0); addVec(7,1,0,0,0);
    addVec(7,1,0,0,0); addVec(7,1,0,0,0); addVec(0,0,0,0,0); addVec(8,0,0,0,0);
    addVec(8,0,1,2,0); addVec(7,0,1,2,0); addVec(1,0,1,2,0); addVec(1,1,0,0,0);
    addVec(0,1,0,0,0); addVec(0,1,1,3,0); addVec(0,1,0,0,0); addVec(0,1,0,0,0);
    addVec(4,1,0,0,1); addVec(7,1,0,0,1); addVec(0,1,0,0,1); addVec(0,1,0,0,1);
    addVec(4,1,0,0,0); addVec(3,1,0,0,0); addVec(2,1,0,0,0); addVec(0,1,1,4,0);
    addVec(6,1,0,0,0); addVec(6,1,0,0,0); addVec(5,1,1,5,0); addVec(0,1,0,0,0);
    addVec(0,1,0,0,0); addVec(0,1,1,6,0); addVec(0,1,0,0,0);
    level = 4'd0;
    for (int i = 0; i < vq.size(); i++) begin
      applyStimulus(vq[i].code, 1'b1, vq[i].ack);
      tick1();
      checkOutput($sformatf("vec%0d valid", i), cmd_valid, vq[i].expValid);
      checkOutput($sformatf("vec%0d cmd", i), cmd, vq[i].expCmd);
      checkOutput($sformatf("vec%0d paused", i), paused, vq[i].expPaused);
    end

    measureGravity(0);
    measureGravity(5);
    measureGravity(12);
    measureGravity(15);

    // Level rise with counter already past the new period fires immediately.
    level = 4'd0;
    doReset();
    applyStimulus(4'd0, 1'b1, 1'b1);
    repeat (60) tick1();
    checkOutput("levelup before", cmd_valid, 0);
    level = 4'd9;
    tick1();
    checkOutput("levelup pending", cmd_valid, 0);
    tick1();
    checkOutput("levelup valid", cmd_valid, 1);
    checkOutput("levelup cmd", cmd, 5);

    // Arbitration: stalled LEFT, then RIGHT pressed and a gravity tick.
    level = 4'd0;
    doReset();
    applyStimulus(4'd0, 1'b1, 1'b0); tick1();
    applyStimulus(4'd7, 1'b1, 1'b0); tick1(); tick1();
    checkOutput("arb left valid", cmd_valid, 1);
    checkOutput("arb left cmd", cmd, 1);
    applyStimulus(4'd0, 1'b1, 1'b0); tick1();
    applyStimulus(4'd8, 1'b1, 1'b0); tick1();
    repeat (110) tick1();
    checkOutput("arb stall valid", cmd_valid, 1);
    checkOutput("arb stall cmd", cmd, 1);
    expV = '{0, 0, 1, 0, 0, 1, 0};
    expC = '{0, 0, 5, 0, 0, 2, 0};
    applyStimulus(4'd8, 1'b1, 1'b1);
    for (int i = 0; i < 7; i++) begin
      tick1();
      checkOutput($sformatf("arb seq%0d valid", i), cmd_valid, expV[i]);
      checkOutput($sformatf("arb seq%0d cmd", i), cmd, expC[i]);
    end

    // Pause freezes gravity and blocks moves; resume continues from frozen count.
    doReset();
    applyStimulus(4'd0, 1'b1, 1'b1);
    repeat (50) tick1();
    applyStimulus(4'd4, 1'b1, 1'b1); tick1();
    frozen = 51;
    checkOutput("pause on", paused, 1);
    seen = 0;
    for (int i = 0; i < 300; i++) begin
      applyStimulus(((i / 10) % 2 == 0) ? 4'd7 : 4'd0, 1'b1, 1'b1);
      tick1();
      if (cmd_valid) seen++;
    end
    checkOutput("pause no cmds", seen, 0);
    checkOutput("pause held", paused, 1);
    applyStimulus(4'd0, 1'b1, 1'b1); tick1();
    applyStimulus(4'd4, 1'b1, 1'b1); tick1();
    checkOutput("pause off", paused, 0);
    applyStimulus(4'd0, 1'b1, 1'b1);
    n = 0;
    do begin tick1(); n++; end while (!cmd_valid && n < 300);
    checkOutput("resume latency", n, GD - frozen + 1);
    checkOutput("resume cmd", cmd, 5);

    // game_active falls mid-handshake: command held until acked.
    doReset();
    applyStimulus(4'd0, 1'b1, 1'b0); tick1();
    applyStimulus(4'd7, 1'b1, 1'b0); tick1(); tick1();
    checkOutput("inactive pre valid", cmd_valid, 1);
    applyStimulus(4'd7, 1'b0, 1'b0);
    repeat (5) tick1();
    checkOutput("inactive held valid", cmd_valid, 1);
    checkOutput("inactive held cmd", cmd, 1);
    applyStimulus(4'd7, 1'b0, 1'b1); tick1();
    checkOutput("inactive acked", cmd_valid, 0);

    // Pause does not drop valid; reset does, and clears pause.
    doReset();
    applyStimulus(4'd0, 1'b1, 1'b0); tick1();
    applyStimulus(4'd7, 1'b1, 1'b0); tick1(); tick1();
    applyStimulus(4'd4, 1'b1, 1'b0); tick1();
    checkOutput("pause inflight paused", paused, 1);
    checkOutput("pause inflight valid", cmd_valid, 1);
    reset = 1'b1;
    tick1();
    checkOutput("midreset valid", cmd_valid, 0);
    checkOutput("midreset paused", paused, 0);
    checkOutput("midreset cmd", cmd, 0);
    reset = 1'b0;

    // Randomized run against the reference model.
    for (int s = 0; s < 4; s++) begin
      int lvl, hold;
      logic [3:0] rc;
      logic ra, rk;
      lvl = $urandom_range(0, 15);
      level = 4'(lvl);
      doReset();
      modelInit(expPeriod(lvl));
      hold = 0;
      rc = 4'd0;
      for (int c = 0; c < 800; c++) begin
        if (hold == 0) begin
          rc = ($urandom_range(0, 99) < 40) ? 4'd0 : 4'($urandom_range(1, 15));
          hold = $urandom_range(1, 6);
        end
        hold--;
        ra = ($urandom_range(0, 99) < 97);
        rk = ($urandom_range(0, 3) != 0);
        applyStimulus(rc, ra, rk);
        modelStep(int'(rc), ra, rk);
        tick1();
        checkOutput($sformatf("rand s%0d c%0d valid", s, c), cmd_valid, (mOut >= 0) ? 1 : 0);
        checkOutput($sformatf("rand s%0d c%0d cmd", s, c), cmd, (mOut >= 0) ? mOut : 0);
        checkOutput($sformatf("rand s%0d c%0d paused", s, c), paused, mPaused ? 1 : 0);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/move_scheduler.md
Name: move_scheduler

Overview:
- Sits between the NES input controller and the grid controller.
- Turns decoded button codes and an internal gravity timer into a single stream of move commands, one at a time, over a valid/ack handshake.
- Arbitrates the grid controller between the player and gravity, and owns pause state.
- Gravity period shortens with game level.

Parameters:
GRAVITY_DIV, 25000000, base gravity period in clk cycles (0.5 s at 50 MHz)
LEVEL_STEP, 1500000, cycles removed from period per level
MIN_PERIOD, 2500000, floor on gravity period
CNT_W, 25, width of gravity counter and period arithmetic

Ports:
clk  input  1  50 MHz system clock
reset  input  1  synchronous, active-high reset
button_code  input  4  button code from input controller (0 none, 1 A, 2 B, 3 Select, 4 Start, 5 Up, 6 Down, 7 Left, 8 Right)
game_active  input  1  high while a game is running
level  input  4  current level, 0-15
cmd_valid  output  1  command presented to grid controller
cmd  output  3  0 NOP, 1 LEFT, 2 RIGHT, 3 ROT_CW, 4 ROT_CCW, 5 DROP, 6 HARD_DROP
cmd_ack  input  1  grid controller accepts cmd this cycle
paused  output  1  game paused

Behaviour:
- Reset values:
  - cmd_valid=0, cmd=0, paused=0
  - state=IDLE, gravity counter=0
  - grav_pending=0, btn_pending=0, prev_code=0
- Press detect:
  - Fires when button_code!=0 and button_code!=prev_code.
  - prev_code<=button_code every cycle.
- Button mapping on press: 1->ROT_CW, 2->ROT_CCW, 5->HARD_DROP, 6->DROP, 7->LEFT, 8->RIGHT. Codes 3 and 9-15 are ignored.
- Move codes:
  - Accepted only when game_active=1 and paused=0; set btn_pending and btn_cmd.
  - A newer press overwrites an unconsumed pending one (single-entry buffer, last wins).
- Start (code 4):
  - Toggles paused when game_active=1; no command is issued.
  - Entering pause clears btn_pending and grav_pending.
- Gravity period:
  - period = max(GRAVITY_DIV - level*LEVEL_STEP, MIN_PERIOD), computed unsigned in CNT_W+4 bits with no underflow wrap.
  - Counter increments only when game_active=1 and paused=0.
  - When counter >= period-1: counter<=0 and grav_pending<=1.
  - A tick while grav_pending is already set merges, so only one DROP is issued.
  - If level rises so counter > period, the tick fires the next cycle.
- game_active=0:
  - Counter held 0, pendings cleared, paused<=0.
  - An in-flight command still completes.
- FSM IDLE:
  - If grav_pending: load cmd=DROP, clear grav_pending, go ISSUE.
  - Else if btn_pending: load cmd=btn_cmd, clear btn_pending, go ISSUE.
  - Gravity has priority over buttons.
- FSM ISSUE:
  - cmd_valid=1, cmd stable.
  - On cmd_ack=1, go GAP.
  - Never drops valid before ack, including on pause or game_active fall.
- FSM GAP: cmd_valid=0, cmd=0, one cycle, then IDLE. This enforces at least one idle cycle between commands.
- Latency: press at input edge N -> pending at N+1 -> cmd_valid high at N+2, if IDLE and no gravity pending.
- Button DROP or HARD_DROP acked: gravity counter resets to 0 that cycle.
- Simultaneous events:
  - Pending cleared by IDLE load in the same cycle a new press or tick arrives: the new event sets pending again, with set winning over clear.
  - Gravity tick and Start toggle in the same cycle: pause wins and grav_pending is cleared.
- Reset mid-handshake: cmd_valid drops on the next edge unconditionally; the grid controller must tolerate this.

Test Plan:
- Setup: GRAVITY_DIV=100, LEVEL_STEP=10, MIN_PERIOD=20.
- Basic move: reset, game_active=1, level=0, button_code 0->7 at cycle 10, cmd_ack tied 1 -> cmd_valid=1 with cmd=1 at cycle 12, cmd_valid=0 at cycle 13, no repeat while code stays 7.
- Gravity: level=0, no buttons, cmd_ack=1 -> DROP every 100 cycles. With level=5 -> every 50 cycles. With level=12 -> every 20 cycles (floor).
- Arbitration: hold cmd_ack=0 while a LEFT is in flight, then press 8 and let a gravity tick occur -> after ack, DROP is issued first, then RIGHT, with one GAP cycle between.
- Overwrite: with cmd_ack=0 stalling, press 7 then 1 -> only ROT_CW is issued after the stalled command.
- Pause: press 4 -> paused=1, counter frozen, presses of 7 ignored, no DROP for 300 cycles. Press 4 again (via 0 between) -> paused=0, gravity resumes from the frozen count.
- Reset/inactive: game_active falls during ISSUE with cmd_ack=0 -> cmd_valid held until ack. reset during ISSUE -> cmd_valid=0 next cycle and paused=0.
